pwm_symbol_demod: RTL and testbench

//  Parametrised pulse-width demodulator: measures the high time of a synchronised, deglitched

---
 rtl/pwm_demod_pkg.sv | 9 +
 rtl/sync_deglitch.sv | 35 +++
 rtl/pwm_symbol_demod.sv | 99 +++++++++
 tb/tb_pwm_symbol_demod.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pwm_demod_pkg.sv
// pwm_demod_pkg: shared FSM states, threshold-count helper and default thresholds for the PWM demodulator
package pwm_demod_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  function automatic int nthr(input int sym_w);
    return (1 << sym_w) - 1;
  endfunction
  localparam int THR_BIN0 = 7;
  localparam logic [23:0] THR_QUAD = {8'd12, 8'd8, 8'd4};
endpackage

// File: rtl/sync_deglitch.sv
// sync_deglitch: synchronises an async line and accepts a new level only after it persists GLITCH cycles
// ports: clk, reset (async, active high), in_data (async line), lvl (stable filtered level)
module sync_deglitch #(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_data,
  output logic lvl
);
  localparam int GW = $clog2(GLITCH + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [GW-1:0] run;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      run <= '0;
      lvl <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in_data};
      if (sync[SYNC_STAGES-1] != lvl) begin
        // the run counts cycles the synced input has disagreed; the GLITCH-th one flips lvl
        if (run == GW'(GLITCH - 1)) begin
          lvl <= ~lvl;
          run <= '0;
        end else begin
          run <= run + GW'(1);
        end
      end else begin
        run <= '0;
      end
    end
  end
endmodule

// File: rtl/pwm_symbol_demod.sv
// pwm_symbol_demod: measures filtered high time of a PWM line and maps it to one of 2**SYM_W symbols
// ports: clk, reset (async, active high), enable (0 forces IDLE), in_data (async PWM line),
//        thr_bus (NTHR ascending CNT_W-bit thresholds), out_data (last good symbol),
//        out_valid (strobe per pulse), out_err (malformed pulse), link_idle (line low >= IDLE_TO)
module pwm_symbol_demod
  import pwm_demod_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int SYM_W = 2,
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH = 2,
  parameter int MIN_W = 2,
  parameter int IDLE_TO = 200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          in_data,
  input  logic [nthr(SYM_W)*CNT_W-1:0]  thr_bus,
  output logic [SYM_W-1:0]              out_data,
  output logic                          out_valid,
  output logic                          out_err,
  output logic                          link_idle
);
  localparam int NTHR = nthr(SYM_W);
  localparam logic [CNT_W-1:0] W_MAX = '1;
  localparam logic [15:0] LOW_MAX = 16'(IDLE_TO);
  state_t state, state_n;
  logic [CNT_W-1:0] w, w_n;
  logic [15:0] low_cnt, low_n;
  logic lvl, lvl_q, rise, dec, bad;
  logic [SYM_W-1:0] sym;
  sync_deglitch #(.SYNC_STAGES(SYNC_STAGES), .GLITCH(GLITCH)) u_sync (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .lvl(lvl)
  );
  // a rise must be a true lvl edge, so re-enabling mid-pulse cannot start a partial pulse
  assign rise = lvl & ~lvl_q;
  assign bad = (w < CNT_W'(MIN_W)) | (w == W_MAX);
  assign link_idle = (state == LOW) && (low_cnt >= LOW_MAX);
  always_comb begin
    sym = '0;
    for (int i = 0; i < NTHR; i++) sym = sym + SYM_W'(w > thr_bus[i*CNT_W +: CNT_W]);
  end
  always_comb begin
    state_n = state;
    w_n = w;
    low_n = low_cnt;
    dec = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      w_n = '0;
      low_n = '0;
    end else begin
      case (state)
        IDLE: if (rise) begin
          state_n = HIGH;
          w_n = CNT_W'(1);
        end
        HIGH: if (lvl) begin
          w_n = (w == W_MAX) ? w : w + CNT_W'(1);
        end else begin
          // the fall cycle is the first low cycle of the gap
          dec = 1'b1;
          state_n = LOW;
          low_n = 16'd1;
        end
        LOW: if (rise) begin
          state_n = HIGH;
          w_n = CNT_W'(1);
        end else begin
          low_n = (low_cnt >= LOW_MAX) ? low_cnt : low_cnt + 16'd1;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      w <= '0;
      low_cnt <= '0;
      lvl_q <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_err <= 1'b0;
    end else begin
      state <= state_n;
      w <= w_n;
      low_cnt <= low_n;
      lvl_q <= lvl;
      out_valid <= dec;
      out_err <= dec & bad;
      if (dec && !bad) out_data <= sym;
    end
  end
endmodule

// File: tb/tb_pwm_symbol_demod.sv
// tb_pwm_symbol_demod: directed pulses against a pulse-level model for a 4-ary and a binary demodulator
module tb_pwm_symbol_demod;
  localparam int S = 2;
  localparam int G = 2;
  localparam int D = S + G;
  localparam int HMAX = 255;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic in_data = 1'b0;
  logic [23:0] thr4 = {8'd12, 8'd8, 8'd4};
  logic [7:0] thr1 = 8'd7;
  logic [1:0] data4;
  logic data1;
  logic valid4, err4, idle4, valid1, err1, idle1;
  int n_pass = 0;
  int n_total = 0;
  pwm_symbol_demod #(.SYM_W(2)) dut4 (
    .clk(clk), .reset(rst), .enable(enable), .in_data(in_data), .thr_bus(thr4),
    .out_data(data4), .out_valid(valid4), .out_err(err4), .link_idle(idle4)
  );
  pwm_symbol_demod #(.SYM_W(1)) dut1 (
    .clk(clk), .reset(rst), .enable(enable), .in_data(in_data), .thr_bus(thr1),
    .out_data(data1), .out_valid(valid1), .out_err(err1), .link_idle(idle1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
  endtask
  bit raw_h[0:8191];
  int cyc = 0;
  bit m_lvl, m_prev, in_pulse, low_armed;
  int hw, low_run;
  bit e_valid, e_err, e_idle, e_d1;
  int e_d4;
  int n_strobe = 0;
  int log_d4[0:63], log_d1[0:63], log_err[0:63], log_cyc[0:63];
  int idle_cycles = 0;
  int idle_rise_cyc = -1;
  bit idle_prev = 0;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid4", valid4, 0); chk("rst_err4", err4, 0); chk("rst_idle4", idle4, 0);
      chk("rst_data4", data4, 0); chk("rst_valid1", valid1, 0); chk("rst_data1", data1, 0);
      raw_h[cyc % 8192] = 0;
      {m_lvl, m_prev, in_pulse, low_armed, e_valid, e_err, e_idle, e_d1} = '0;
      hw = 0; low_run = 0; e_d4 = 0; idle_prev = 0;
    end else begin
      chk("valid4", valid4, e_valid); chk("err4", err4, e_err); chk("data4", data4, e_d4);
      chk("idle4", idle4, e_idle); chk("valid1", valid1, e_valid); chk("err1", err1, e_err);
      chk("data1", data1, e_d1); chk("idle1", idle1, e_idle);
      if (valid4 && n_strobe < 64) begin
        log_d4[n_strobe] = data4; log_d1[n_strobe] = data1;
        log_err[n_strobe] = err4; log_cyc[n_strobe] = cyc;
        n_strobe++;
      end
      if (idle4) idle_cycles++;
      if (idle4 && !idle_prev) idle_rise_cyc = cyc;
      idle_prev = idle4;
      raw_h[cyc % 8192] = in_data;
      // filtered level: flips D cycles after the start of a raw run of G equal samples that opposes it
      if (cyc >= D) begin
        bit v, same;
        v = raw_h[(cyc - D) % 8192];
        same = 1;
        for (int j = 0; j < G; j++) if (raw_h[(cyc - D + j) % 8192] != v) same = 0;
        if (same && v != m_lvl) m_lvl = v;
      end
      e_valid = 0; e_err = 0;
      if (!enable) begin
        in_pulse = 0; low_armed = 0;
      end else if (m_lvl && !m_prev) begin
        in_pulse = 1; hw = 1; low_armed = 0;
      end else if (m_lvl && in_pulse) begin
        hw = (hw < HMAX) ? hw + 1 : HMAX;
      end else if (!m_lvl && m_prev && in_pulse) begin
        e_valid = 1;
        if (hw < 2 || hw == HMAX) e_err = 1;
        else begin
          e_d4 = (hw > 4) + (hw > 8) + (hw > 12);
          e_d1 = hw > 7;
        end
        in_pulse = 0; low_armed = 1; low_run = 1;
      end else if (!m_lvl && low_armed) begin
        low_run = (low_run < 200) ? low_run + 1 : 200;
      end
      e_idle = low_armed && low_run >= 200;
      m_prev = m_lvl;
    end
    cyc++;
  end
  task automatic go(input logic v, input int n);
    in_data = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input int h, input int l);
    go(1'b1, h);
    go(1'b0, l);
  endtask
  initial begin
    int base, ic;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    go(1'b0, 6);
    pulse(5, 12); pulse(10, 12);
    chk("bin_cnt", n_strobe, 2);
    chk("bin_sym0", log_d1[0], 0); chk("bin_sym1", log_d1[1], 1);
    chk("bin_err0", log_err[0], 0); chk("bin_err1", log_err[1], 0);
    base = n_strobe;
    pulse(3, 12); pulse(6, 12); pulse(10, 12); pulse(14, 12);
    chk("quad_cnt", n_strobe - base, 4);
    chk("quad_sym3", log_d4[base], 0); chk("quad_sym6", log_d4[base+1], 1);
    chk("quad_sym10", log_d4[base+2], 2); chk("quad_sym14", log_d4[base+3], 3);
    chk("quad_bin14", log_d1[base+3], 1);
    base = n_strobe;
    pulse(1, 12);
    chk("glitch1_cnt", n_strobe, base);
    pulse(2, 12);
    chk("glitch2_cnt", n_strobe, base + 1);
    chk("glitch2_sym", log_d4[base], 0); chk("glitch2_err", log_err[base], 0);
    base = n_strobe;
    pulse(300, 12);
    chk("sat_cnt", n_strobe, base + 1);
    chk("sat_err", log_err[base], 1); chk("sat_keep", log_d4[base], 0);
    ic = idle_cycles;
    pulse(5, 199); pulse(5, 12);
    chk("idle199", idle_cycles, ic);
    pulse(5, 200);
    base = n_strobe - 1;
    pulse(5, 12);
    chk("idle200_len", idle_cycles, ic + 1);
    chk("idle200_at", idle_rise_cyc - log_cyc[base], 199);
    chk("idle_cleared", idle4, 0);
    base = n_strobe;
    go(1'b1, 6);
    rst = 1'b1; in_data = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_data", data4, 0); chk("rst_out_idle", idle4, 0);
    go(1'b0, 12);
    chk("rst_no_strobe", n_strobe, base);
    go(1'b1, 8);
    enable = 1'b0;
    go(1'b1, 3);
    enable = 1'b1;
    go(1'b1, 5); go(1'b0, 12);
    chk("en_no_strobe", n_strobe, base);
    go(1'b1, 6); go(1'b0, D);
    enable = 1'b0;
    go(1'b0, 1);
    enable = 1'b1;
    go(1'b0, 12);
    chk("en_drop_decide", n_strobe, base);
    pulse(6, 12);
    chk("post_cnt", n_strobe, base + 1);
    chk("post_sym", log_d4[base], 1); chk("post_err", log_err[base], 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
